// File: rtl/multicycle_main_control.sv
// multicycle_main_control
//   Main control FSM of the multicycle MIPS datapath. It sequences
//   fetch / decode / execute for each opcode and drives the datapath
//   selects plus the 2-bit ALU operation class.
//
//   Optional feature macro: MC_CTRL_ORI_EN
//     defined   : ORI (6'h0D) executes through ORI_EX -> ALUI_WB with a
//                 zero-extended immediate and alu_op = 11 (or).
//     undefined : ORI_EX is unreachable, 6'h0D traps like any other
//                 unsupported opcode, and ext_zero is held at 0.
//
//   Memory handshake: in FETCH, MEMRD and MEMWR the FSM raises exactly one
//   of mem_read / mem_write and holds it, with iord stable, on every cycle
//   until the memory returns mem_ready = 1. That cycle completes the access
//   and the FSM leaves the state on the next edge. mem_ready is ignored in
//   every other state, and mem_read / mem_write are never high together.
module multicycle_main_control (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       ext_zero,
    output logic       illegal_op,
    output logic [3:0] state
);

    // Supported opcodes (IR[31:26])
    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ORI  = 6'h0D;

    // ALU source B selects
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM2 = 2'b11;

    // ALU operation classes
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OR    = 2'b11;

    // PC source selects
    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_OUT  = 2'b01;
    localparam logic [1:0] PCSRC_JUMP = 2'b10;

    // State encoding is visible on the debug port, so it is fixed explicitly.
    // Code 15 is unused and recovers to FETCH.
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMRD    = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWR    = 4'd6,
        S_RTYPE_EX = 4'd7,
        S_RTYPE_WB = 4'd8,
        S_BEQ      = 4'd9,
        S_JUMP     = 4'd10,
        S_ADDI_EX  = 4'd11,
        S_ALUI_WB  = 4'd12,
        S_ORI_EX   = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [5:0] op_q;           // opcode captured in DECODE, steers MEMADR
    logic       pc_write;
    logic       pc_write_cond;

    // State register; reset aborts any access in flight and parks in IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Opcode is only looked at in DECODE; keep a copy for the LW/SW split.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q <= 6'h00;
        end else if (state_q == S_DECODE) begin
            op_q <= opcode;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW,
                    OP_SW:   state_d = S_MEMADR;
                    OP_R:    state_d = S_RTYPE_EX;
                    OP_BEQ:  state_d = S_BEQ;
                    OP_J:    state_d = S_JUMP;
                    OP_ADDI: state_d = S_ADDI_EX;
`ifdef MC_CTRL_ORI_EN
                    OP_ORI:  state_d = S_ORI_EX;
`endif
                    default: state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWR:    state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_RTYPE_EX: state_d = S_RTYPE_WB;
            S_RTYPE_WB: state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_ADDI_EX:  state_d = S_ALUI_WB;
            S_ALUI_WB:  state_d = S_FETCH;
`ifdef MC_CTRL_ORI_EN
            S_ORI_EX:   state_d = S_ALUI_WB;
`endif
            S_TRAP:     state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Output decode: Moore outputs, except the FETCH PC/IR load which
    // completes on the cycle the memory returns the instruction.
    always_comb begin
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_op        = ALU_ADD;
        pc_src        = PCSRC_ALU;
        ext_zero      = 1'b0;
        illegal_op    = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut.
                alu_src_b = SRCB_IMM2;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_RTYPE_EX: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_RTYPE_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BEQ: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_src        = PCSRC_OUT;
                pc_write_cond = 1'b1;
            end
            S_JUMP: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_ALUI_WB: begin
                reg_write = 1'b1;
            end
`ifdef MC_CTRL_ORI_EN
            S_ORI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_OR;
                ext_zero  = 1'b1;
            end
`endif
            S_TRAP: begin
                // TRAP lasts one cycle, so this is a single-cycle pulse.
                illegal_op = 1'b1;
            end
            default: ;
        endcase
    end

    assign pc_en = pc_write | (pc_write_cond & zero);
    assign state = state_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Self-checking bench for multicycle_main_control: reset, a table of
// directed instructions, randomized instructions against a phase-level
// model, and a reset-abort sequence.
module tb_multicycle_main_control;

  logic       clk;
  logic       reset_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst;
  logic       mem_to_reg, reg_write, alu_src_a, ext_zero, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;

  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       ext_zero;
    logic       illegal_op;
  } ctl_t;

  ctl_t act;
  assign act = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                reg_write, alu_src_a, alu_src_b, alu_op, pc_src, ext_zero, illegal_op};

  multicycle_main_control dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .ext_zero   (ext_zero),
    .illegal_op (illegal_op),
    .state      (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  // Each expected cycle: {state[3:0], mem_ready, zero}
  logic [5:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

`ifdef MC_CTRL_ORI_EN
  localparam int ORI_LAT = 4;
`else
  localparam int ORI_LAT = 3;
`endif

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Control word each phase must show, written from the phase descriptions.
  function automatic ctl_t ctl_of(input logic [3:0] st, input logic mr, input logic z);
    ctl_t c;
    c = '0;
    case (st)
      4'd1:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_en = mr; end
      4'd2:  c.alu_src_b = 2'b11;
      4'd3:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      4'd4:  begin c.mem_read = 1; c.iord = 1; end
      4'd5:  begin c.reg_write = 1; c.mem_to_reg = 1; end
      4'd6:  begin c.mem_write = 1; c.iord = 1; end
      4'd7:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      4'd8:  begin c.reg_write = 1; c.reg_dst = 1; end
      4'd9:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.pc_en = z; end
      4'd10: begin c.pc_src = 2'b10; c.pc_en = 1; end
      4'd11: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      4'd12: c.reg_write = 1;
      4'd13: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = 2'b11; c.ext_zero = 1; end
      4'd14: c.illegal_op = 1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // A memory phase repeats with mem_ready low 'waits' times, then completes.
  task automatic push_phase(input logic [3:0] st, input bit is_mem, input int waits,
                            input logic bz, input bit use_bz);
    logic zz;
    if (is_mem) begin
      for (int i = 0; i < waits; i++) begin
        zz = use_bz ? bz : 1'($urandom_range(0, 1));
        exp_q.push_back({st, 1'b0, zz});
      end
      zz = use_bz ? bz : 1'($urandom_range(0, 1));
      exp_q.push_back({st, 1'b1, zz});
    end else begin
      zz = use_bz ? bz : 1'($urandom_range(0, 1));
      exp_q.push_back({st, 1'($urandom_range(0, 1)), zz});
    end
  endtask

  // Reference model: the ordered list of phases an instruction walks through.
  task automatic plan(input logic [5:0] op, input logic bz, input int waits);
    exp_q.delete();
    push_phase(4'd1, 1, waits, 0, 0);
    push_phase(4'd2, 0, 0, 0, 0);
    case (op)
      6'h23: begin push_phase(4'd3, 0, 0, 0, 0); push_phase(4'd4, 1, waits, 0, 0);
                   push_phase(4'd5, 0, 0, 0, 0); end
      6'h2B: begin push_phase(4'd3, 0, 0, 0, 0); push_phase(4'd6, 1, waits, 0, 0); end
      6'h00: begin push_phase(4'd7, 0, 0, 0, 0); push_phase(4'd8, 0, 0, 0, 0); end
      6'h08: begin push_phase(4'd11, 0, 0, 0, 0); push_phase(4'd12, 0, 0, 0, 0); end
      6'h04: push_phase(4'd9, 0, 0, bz, 1);
      6'h02: push_phase(4'd10, 0, 0, 0, 0);
`ifdef MC_CTRL_ORI_EN
      6'h0D: begin push_phase(4'd13, 0, 0, 0, 0); push_phase(4'd12, 0, 0, 0, 0); end
`endif
      default: push_phase(4'd14, 0, 0, 0, 0);
    endcase
  endtask

  // ---------------- driver ----------------
  // Entered at a negedge with the DUT in FETCH; returns at the negedge where
  // the DUT is back in FETCH for the next instruction.
  task automatic run_instr(input logic [5:0] op, input logic bz, input int waits,
                           input string tag, output int lat, output int plen);
    logic [5:0] e;
    bit left;
    bit done;
    plan(op, bz, waits);
    plen = exp_q.size();
    lat  = 0;
    left = 0;
    done = 0;
    for (int c = 0; c < 64; c++) begin
      if (state != 4'd1) left = 1;
      else if (left) begin done = 1; break; end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : {4'd1, 1'b1, 1'b0};
      mem_ready = e[1];
      zero      = e[0];
      opcode    = (e[5:2] == 4'd1) ? 6'($urandom_range(0, 63)) : op;
      #1;
      check({tag, " state"}, 32'(state), 32'(e[5:2]));
      check({tag, " ctl"}, 32'(act), 32'(ctl_of(e[5:2], e[1], e[0])));
      check({tag, " rd_wr_excl"}, 32'(mem_read & mem_write), 32'd0);
      lat++;
      @(posedge clk);
      @(negedge clk);
    end
    if (!done) check({tag, " return_timeout"}, 32'(state), 32'd1);
    check({tag, " leftover"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [5:0] op;
    logic       z;
    int         waits;
    int         lat;
    string      tag;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int lat, plen;
    logic [5:0] rop;
    logic [5:0] ops[8];

    vecs[0]  = '{6'h23, 1'b0, 0, 5, "lw"};
    vecs[1]  = '{6'h2B, 1'b0, 2, 8, "sw_wait2"};
    vecs[2]  = '{6'h00, 1'b0, 0, 4, "rtype"};
    vecs[3]  = '{6'h08, 1'b0, 0, 4, "addi"};
    vecs[4]  = '{6'h04, 1'b1, 0, 3, "beq_taken"};
    vecs[5]  = '{6'h04, 1'b0, 0, 3, "beq_not"};
    vecs[6]  = '{6'h02, 1'b0, 0, 3, "jump"};
    vecs[7]  = '{6'h0D, 1'b0, 0, ORI_LAT, "ori"};
    vecs[8]  = '{6'h3F, 1'b0, 0, 3, "illegal"};
    vecs[9]  = '{6'h23, 1'b0, 1, 7, "lw_wait1"};
    vecs[10] = '{6'h2B, 1'b1, 0, 4, "sw"};

    // reset held low for three cycles
    reset_n   = 1'b0;
    mem_ready = 1'b0;
    zero      = 1'b0;
    opcode    = 6'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_ctl", 32'(act), 32'd0);
    reset_n = 1'b1;
    #1;
    check("idle_state", 32'(state), 32'd0);
    check("idle_ctl", 32'(act), 32'd0);
    @(negedge clk);
    check("first_fetch_state", 32'(state), 32'd1);
    check("first_fetch_ctl", 32'(act), 32'(ctl_of(4'd1, 1'b0, 1'b0)));

    // directed instructions
    for (int i = 0; i < 11; i++) begin
      run_instr(vecs[i].op, vecs[i].z, vecs[i].waits, vecs[i].tag, lat, plen);
      check({vecs[i].tag, " latency"}, 32'(lat), 32'(vecs[i].lat));
    end

    // randomized instructions
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h0D, 6'h00};
    for (int n = 0; n < 40; n++) begin
      int k;
      k = $urandom_range(0, 7);
      rop = ops[k];
      if (k == 7) begin
        do rop = 6'($urandom_range(0, 63));
        while (rop inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h0D});
      end
      run_instr(rop, 1'($urandom_range(0, 1)), $urandom_range(0, 3), "rand", lat, plen);
      check("rand latency", 32'(lat), 32'(plen));
    end

    // reset in the middle of a stalled load read
    opcode    = 6'h23;
    mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    check("abort_memrd_state", 32'(state), 32'd4);
    @(negedge clk);
    check("abort_memrd_held", 32'(act), 32'(ctl_of(4'd4, 1'b0, 1'b0)));
    reset_n = 1'b0;
    #1;
    check("abort_state", 32'(state), 32'd0);
    check("abort_ctl", 32'(act), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("abort_idle", 32'(state), 32'd0);
    @(negedge clk);
    check("abort_refetch", 32'(state), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
